// File: rtl/user_ip_ctrl.sv
// user_ip_ctrl: APB4 front end for a bank of user-IP slots with one shared GPIO pad group.
//
// Address map (paddr[11:8]):
//   0      local registers: CTRL 0x00 (rw [3:0] sel, [4] en), STAT 0x04 (ro [0] busy,
//          [7:4] owner, [8] owner_valid), GUARD 0x08 (rw [7:0] guard cycles).
//   k>=1   window of slot k-1, forwarded as ip_paddr = paddr[7:0] when slot k-1 owns the pads.
//
// Ports:
//   clk_i, rst_n_i                 clock, asynchronous active-low reset
//   paddr/psel/penable/pwrite/pwdata, prdata/pready/pslverr   upstream APB4 slave
//   ip_psel/ip_paddr/ip_penable/ip_pwrite/ip_pwdata, ip_prdata/ip_pready/ip_pslverr
//                                  downstream APB4 master, one select bit per slot
//   ip_gpio_out/ip_gpio_oen        per-slot pad requests
//   gpio_out/gpio_oen              pads (oen=1 tri-states the pad)
//
// Build option: define USER_IP_CTRL_TIMEOUT_EN to abort a downstream access that has not
// seen ip_pready within TO_CYC access cycles (answered with pslverr=1, prdata=0).
module user_ip_ctrl #(
  parameter int unsigned NUM_IP = 4,
  parameter int unsigned GPIO_W = 8,
  parameter int unsigned TO_CYC = 255
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [11:0]                paddr,
  input  logic                       psel,
  input  logic                       penable,
  input  logic                       pwrite,
  input  logic [31:0]                pwdata,
  output logic [31:0]                prdata,
  output logic                       pready,
  output logic                       pslverr,
  output logic [NUM_IP-1:0]          ip_psel,
  output logic [7:0]                 ip_paddr,
  output logic                       ip_penable,
  output logic                       ip_pwrite,
  output logic [31:0]                ip_pwdata,
  input  logic [NUM_IP*32-1:0]       ip_prdata,
  input  logic [NUM_IP-1:0]          ip_pready,
  input  logic [NUM_IP-1:0]          ip_pslverr,
  input  logic [NUM_IP*GPIO_W-1:0]   ip_gpio_out,
  input  logic [NUM_IP*GPIO_W-1:0]   ip_gpio_oen,
  output logic [GPIO_W-1:0]          gpio_out,
  output logic [GPIO_W-1:0]          gpio_oen
);

  if (NUM_IP < 1 || NUM_IP > 15) begin : g_bad_num_ip
    $error("user_ip_ctrl: NUM_IP must be in 1..15");
  end
  if (TO_CYC < 1) begin : g_bad_to_cyc
    $error("user_ip_ctrl: TO_CYC must be at least 1");
  end

  typedef enum logic [1:0] {AIdle, ASetup, AAccess, ADone} apb_state_e;
  typedef enum logic [1:0] {PadOff, PadGuard, PadActive} pad_state_e;

  apb_state_e apb_q, apb_d;
  pad_state_e pad_q, pad_d;

  logic [3:0]  ctrl_sel_q;
  logic        ctrl_en_q;
  logic [7:0]  guard_q;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  owner_q, owner_d;
  logic        owner_valid_q, owner_valid_d;
  logic [3:0]  slot_q, slot_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  // Upstream decode
  logic        access, is_local, win_ok, busy;
  logic [3:0]  page, slot;
  logic        ctrl_wr, ctrl_bad, ctrl_chg, guard_wr;
  logic [31:0] local_rdata;

  assign access   = psel & penable;
  assign page     = paddr[11:8];
  assign slot     = page - 4'd1;
  assign is_local = (page == 4'd0);
  // Only the slot that currently owns the pads may be reached through its window.
  assign win_ok   = !is_local && (32'(page) <= NUM_IP) && owner_valid_q && (owner_q == slot);

  assign ctrl_wr  = access && pwrite && is_local && (paddr[7:0] == 8'h00) && (apb_q == AIdle);
  assign guard_wr = access && pwrite && is_local && (paddr[7:0] == 8'h08) && (apb_q == AIdle);
  assign ctrl_bad = 32'(pwdata[3:0]) >= NUM_IP;
  assign ctrl_chg = ctrl_wr && !ctrl_bad &&
                    ((pwdata[3:0] != ctrl_sel_q) || (pwdata[4] != ctrl_en_q));

  // busy reports that the pads are claimed: guarding or handed to a slot.
  assign busy = (pad_q != PadOff);

  always_comb begin
    local_rdata = '0;
    case (paddr[7:0])
      8'h00:   local_rdata = {27'd0, ctrl_en_q, ctrl_sel_q};
      8'h04:   local_rdata = {23'd0, owner_valid_q, owner_q, 3'd0, busy};
      8'h08:   local_rdata = {24'd0, guard_q};
      default: local_rdata = '0;
    endcase
  end

  // Response of the slot being forwarded to
  logic        sel_pready, sel_pslverr;
  logic [31:0] sel_prdata;

  always_comb begin
    sel_pready  = 1'b0;
    sel_pslverr = 1'b0;
    sel_prdata  = '0;
    for (int i = 0; i < int'(NUM_IP); i++) begin
      if (slot_q == 4'(i)) begin
        sel_pready  = ip_pready[i];
        sel_pslverr = ip_pslverr[i];
        sel_prdata  = ip_prdata[i*32 +: 32];
      end
    end
  end

`ifdef USER_IP_CTRL_TIMEOUT_EN
  localparam int unsigned ToW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic           to_hit;

  assign to_hit = (32'(to_cnt_q) == TO_CYC - 1);

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (apb_q == ASetup)       to_cnt_d = '0;
    else if (apb_q == AAccess) to_cnt_d = to_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) to_cnt_q <= '0;
    else          to_cnt_q <= to_cnt_d;
  end
`endif

  // APB forwarding FSM and upstream response
  always_comb begin
    apb_d   = apb_q;
    slot_d  = slot_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = '0;
    unique case (apb_q)
      AIdle: begin
        if (access) begin
          if (is_local) begin
            pready  = 1'b1;
            prdata  = local_rdata;
            pslverr = ctrl_wr && ctrl_bad;
          end else if (win_ok) begin
            apb_d  = ASetup;
            slot_d = slot;
          end else begin
            pready  = 1'b1;
            pslverr = 1'b1;
          end
        end
      end
      ASetup: apb_d = AAccess;
      AAccess: begin
        if (sel_pready) begin
          apb_d   = ADone;
          rdata_d = sel_prdata;
          err_d   = sel_pslverr;
        end
`ifdef USER_IP_CTRL_TIMEOUT_EN
        else if (to_hit) begin
          apb_d   = ADone;
          rdata_d = '0;
          err_d   = 1'b1;
        end
`endif
      end
      ADone: begin
        pready  = 1'b1;
        prdata  = rdata_q;
        pslverr = err_q;
        apb_d   = AIdle;
      end
      default: apb_d = AIdle;
    endcase
    // Local answers are combinational from the request, so mask them while in reset.
    if (!rst_n_i) begin
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = '0;
    end
  end

  assign ip_paddr   = paddr[7:0];
  assign ip_pwrite  = pwrite;
  assign ip_pwdata  = pwdata;
  assign ip_penable = (apb_q == AAccess);

  always_comb begin
    ip_psel = '0;
    for (int i = 0; i < int'(NUM_IP); i++) begin
      ip_psel[i] = ((apb_q == ASetup) || (apb_q == AAccess)) && (slot_q == 4'(i));
    end
  end

  // Pad ownership FSM; a CTRL change always (re)starts the guard with the new target.
  always_comb begin
    pad_d         = pad_q;
    cnt_d         = cnt_q;
    owner_d       = owner_q;
    owner_valid_d = owner_valid_q;
    if (ctrl_chg) begin
      pad_d = PadGuard;
      cnt_d = guard_q;
    end else if (pad_q == PadGuard) begin
      if (cnt_q == 8'd0) begin
        pad_d         = ctrl_en_q ? PadActive : PadOff;
        owner_d       = ctrl_sel_q;
        owner_valid_d = ctrl_en_q;
      end else begin
        cnt_d = cnt_q - 8'd1;
      end
    end
  end

  always_comb begin
    gpio_out = '0;
    gpio_oen = '1;
    if (pad_q == PadActive) begin
      for (int i = 0; i < int'(NUM_IP); i++) begin
        if (owner_q == 4'(i)) begin
          gpio_out = ip_gpio_out[i*GPIO_W +: GPIO_W];
          gpio_oen = ip_gpio_oen[i*GPIO_W +: GPIO_W];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      apb_q         <= AIdle;
      slot_q        <= '0;
      rdata_q       <= '0;
      err_q         <= 1'b0;
      pad_q         <= PadOff;
      cnt_q         <= '0;
      owner_q       <= '0;
      owner_valid_q <= 1'b0;
      ctrl_sel_q    <= '0;
      ctrl_en_q     <= 1'b0;
      guard_q       <= 8'd16;
    end else begin
      apb_q         <= apb_d;
      slot_q        <= slot_d;
      rdata_q       <= rdata_d;
      err_q         <= err_d;
      pad_q         <= pad_d;
      cnt_q         <= cnt_d;
      owner_q       <= owner_d;
      owner_valid_q <= owner_valid_d;
      if (ctrl_chg) begin
        ctrl_sel_q <= pwdata[3:0];
        ctrl_en_q  <= pwdata[4];
      end
      if (guard_wr) guard_q <= pwdata[7:0];
    end
  end

endmodule

// File: doc/user_ip_ctrl.md
USER_IP_CTRL -- requirements
Module: user_ip_ctrl

Interface
REQ-001 SHALL have parameter NUM_IP, default 4, number of user-IP slots (legal 1..15).
REQ-002 SHALL have parameter GPIO_W, default 8, shared pad width.
REQ-003 SHALL have parameter TO_CYC, default 255, downstream wait limit in cycles.
REQ-004 SHALL have clk_i  in  1  sole clock; rst_n_i  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have paddr/psel/penable/pwrite/pwdata  in  12/1/1/1/32  upstream APB4 request.
REQ-006 SHALL have prdata/pready/pslverr  out  32/1/1  upstream APB4 response.
REQ-007 SHALL have ip_psel  out  NUM_IP  one-hot slot select; ip_paddr  out  8; ip_penable, ip_pwrite  out  1; ip_pwdata  out  32.
REQ-008 SHALL have ip_prdata  in  NUM_IP*32; ip_pready, ip_pslverr  in  NUM_IP each.
REQ-009 SHALL have ip_gpio_out, ip_gpio_oen  in  NUM_IP*GPIO_W  per-slot pad requests; gpio_out, gpio_oen  out  GPIO_W  pads (oen=1: pad tri-stated).

Function
REQ-010 SHALL decode paddr[11:8]: 0 = local registers, k in 1..NUM_IP = slot k-1 window, ip_paddr = paddr[7:0].
REQ-011 SHALL provide CTRL @0x00 (rw: [3:0] sel, [4] en), STAT @0x04 (ro: [0] busy, [7:4] owner, [8] owner_valid), GUARD @0x08 (rw: [7:0] guard cycles); other local offsets read 0, writes ignored, no error.
REQ-012 SHALL complete local accesses with pready=1 in the first access cycle (zero wait states).
REQ-013 SHALL forward window accesses through FSM A_IDLE -> A_SETUP (ip_psel=1, ip_penable=0, one cycle) -> A_ACCESS (ip_penable=1 until ip_pready) -> A_DONE (upstream pready=1, registered prdata/pslverr, one cycle) -> A_IDLE.
REQ-014 SHALL hold upstream pready=0 while A_SETUP/A_ACCESS; minimum window latency 3 cycles from upstream access phase.
REQ-015 SHALL respond pslverr=1, prdata=0, zero wait, with no downstream select, for window k-1 >= NUM_IP or slot not the current valid owner.
REQ-016 SHALL respond pslverr=1 and leave CTRL unchanged when a CTRL write has sel >= NUM_IP.
REQ-017 SHALL run pad FSM OFF / GUARD / ACTIVE; OFF and GUARD drive gpio_out=0, gpio_oen=all ones; ACTIVE drives the owner slot's ip_gpio_out/ip_gpio_oen.
REQ-018 SHALL on a CTRL write changing sel or en load a counter with GUARD and enter GUARD; after counter reaches 0 go to ACTIVE (en=1) or OFF (en=0); GUARD=0 spends exactly one GUARD cycle.
REQ-019 SHALL treat a CTRL write with sel and en unchanged as a no-op for the pad FSM.
REQ-020 SHALL restart the guard count with the new target when CTRL is written during GUARD.
REQ-021 SHALL set STAT.busy=1 in GUARD; owner/owner_valid update only on entering ACTIVE or OFF.
REQ-022 SHALL never drive more than one ip_psel bit; unselected slots see ip_penable=0.

Reset
REQ-023 SHALL on rst_n_i low asynchronously force: CTRL=0, GUARD=16, pad FSM OFF, APB FSM A_IDLE, guard counter 0, owner_valid=0.
REQ-024 SHALL hold outputs in reset: pready=0, pslverr=0, prdata=0, ip_psel=0, ip_penable=0, gpio_out=0, gpio_oen=all ones.
REQ-025 SHALL abandon an in-flight forwarded transfer on reset without completing it.

Configuration
REQ-026 SHALL with USER_IP_CTRL_TIMEOUT_EN defined count A_ACCESS cycles and, at TO_CYC without ip_pready, drop ip_psel and go to A_DONE with pslverr=1, prdata=0.
REQ-027 SHALL without USER_IP_CTRL_TIMEOUT_EN wait in A_ACCESS indefinitely, with no counter logic.

Verification
REQ-028 SHALL cover: reset, read STAT -> 0x000; read GUARD -> 0x10; gpio_oen=0xFF.
REQ-029 SHALL cover: GUARD=3, write CTRL=0x12 -> busy=1 for 4 cycles, then STAT=0x121, pads follow slot 2.
REQ-030 SHALL cover: owner slot 1, read 0x204 with ip_pready after 2 waits -> upstream pready 5 cycles after access, prdata = slot-1 data.
REQ-031 SHALL cover: read 0x304 while owner is slot 1 -> pslverr=1, prdata=0, ip_psel=0.
REQ-032 SHALL cover: CTRL write sel=7 with NUM_IP=4 -> pslverr=1, CTRL unchanged.
REQ-033 SHALL cover (TIMEOUT_EN, TO_CYC=8): slot never ready -> pslverr=1 after 8 access cycles, next transfer succeeds.
